// File: rtl/row_filter_sequencer_pkg.sv
// Shared constants, FSM encoding and the gray-level helper for the row filter sequencer.
// Geometry defaults live here; the top module can override COLS/ROWS/AW per instance.
package row_filter_sequencer_pkg;
  localparam int PIX_W    = 8;
  localparam int PIX_BITS = 3 * PIX_W;
  localparam int DEF_COLS = 256;
  localparam int DEF_ROWS = 256;
  localparam int DEF_AW   = 8;

  localparam logic [PIX_BITS-1:0] WHITE_PIX = {PIX_BITS{1'b1}};
  localparam logic [PIX_BITS-1:0] BLACK_PIX = {PIX_BITS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Sum is two bits wider than a channel so 3*max never overflows.
  function automatic logic [PIX_W+1:0] gray_of(input logic [PIX_BITS-1:0] pix);
    logic [PIX_W+1:0] sum;
    sum = {2'b00, pix[PIX_BITS-1 -: PIX_W]}
        + {2'b00, pix[2*PIX_W-1 -: PIX_W]}
        + {2'b00, pix[PIX_W-1:0]};
    return sum / (PIX_W+2)'(3);
  endfunction
endpackage

// File: rtl/row_filter_sequencer_kernel.sv
// Combinational binary-threshold kernel: maps the mid window row to a black/white row.
// Pixel 0 sits at the MSBs; each pixel is R,G,B from most to least significant.
module row_threshold_kernel
  import row_filter_sequencer_pkg::*;
#(
  parameter int COLS = DEF_COLS
) (
  input  logic [COLS*PIX_BITS-1:0] mid_i,
  input  logic [PIX_W-1:0]         thr_i,
  output logic [COLS*PIX_BITS-1:0] row_o
);
  for (genvar i = 0; i < COLS; i++) begin : g_pix
    logic [PIX_BITS-1:0] pix;
    assign pix = mid_i[COLS*PIX_BITS-1-PIX_BITS*i -: PIX_BITS];
    assign row_o[COLS*PIX_BITS-1-PIX_BITS*i -: PIX_BITS] =
      (gray_of(pix) > {2'b00, thr_i}) ? WHITE_PIX : BLACK_PIX;
  end
endmodule

// File: rtl/row_filter_sequencer.sv
// Frame controller: reads rows one at a time, keeps a 3-row edge-replicated window and
// writes one thresholded row per read, with at most one read or write outstanding.
module row_filter_sequencer
  import row_filter_sequencer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = DEF_AW
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [PIX_W-1:0]         threshold,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_req,
  output logic [AW-1:0]            rd_addr,
  input  logic                     rd_valid,
  input  logic [COLS*PIX_BITS-1:0] rd_data,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [COLS*PIX_BITS-1:0] wr_data,
  input  logic                     wr_ready
);
  if (ROWS < 2) begin : g_bad_rows
    $error("row_filter_sequencer: ROWS must be at least 2");
  end
  if ((1 << AW) < ROWS) begin : g_bad_aw
    $error("row_filter_sequencer: AW too narrow for ROWS");
  end

  localparam logic [AW:0]   ROWS_C   = (AW+1)'(ROWS);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS-1);

  state_e                   state_q;
  logic [AW:0]              rcnt_q;
  logic [PIX_W-1:0]         thr_q;
  logic [COLS*PIX_BITS-1:0] top_q, mid_q, bot_q;
  logic                     busy_q, done_q, rd_req_q, wr_en_q;
  logic [AW-1:0]            rd_addr_q, wr_addr_q;
  logic [COLS*PIX_BITS-1:0] kernel_row;
  logic                     window_unused;

  // The current kernel only needs mid; top is kept for a future 3-row kernel.
  assign window_unused = ^top_q;

  row_threshold_kernel #(.COLS(COLS)) u_kernel (
    .mid_i (mid_q),
    .thr_i (thr_q),
    .row_o (kernel_row)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      thr_q     <= '0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            thr_q     <= threshold;
            rcnt_q    <= '0;
            rd_req_q  <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_RD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (rd_valid) begin
            rcnt_q <= rcnt_q + (AW+1)'(1);
            if (rcnt_q == '0) begin
              // First row fills the whole window (top-edge replication).
              top_q     <= rd_data;
              mid_q     <= rd_data;
              bot_q     <= rd_data;
              rd_addr_q <= AW'(1);
            end else begin
              top_q     <= mid_q;
              mid_q     <= bot_q;
              bot_q     <= rd_data;
              rd_req_q  <= 1'b0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= rcnt_q[AW-1:0] - AW'(1);
              state_q   <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (wr_ready) begin
            if (rcnt_q < ROWS_C) begin
              wr_en_q   <= 1'b0;
              rd_req_q  <= 1'b1;
              rd_addr_q <= rcnt_q[AW-1:0];
              state_q   <= ST_RD;
            end else begin
              // Bottom-edge replication: bot stays, window slides once more.
              top_q     <= mid_q;
              mid_q     <= bot_q;
              wr_addr_q <= LAST_ROW;
              state_q   <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (wr_ready) begin
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          rd_req_q <= 1'b0;
          wr_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_en_q ? kernel_row : '0;
endmodule

// File: tb/tb_row_filter_sequencer.sv
// Self-checking bench: a 4-row, 2-column frame store driven cycle by cycle, with a
// reference model computing expected rows, windows, ordering and frame timing.
module tb_row_filter_sequencer;
  localparam int COLS = 2;
  localparam int ROWS = 4;
  localparam int AW   = 8;
  localparam int RW   = COLS * 24;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [7:0]    threshold;
  logic          busy, done, rd_req, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_valid, wr_ready;
  logic [RW-1:0] rd_data, wr_data;

  logic [RW-1:0] mem [ROWS];
  int checks = 0;
  int errors = 0;

  row_filter_sequencer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .threshold(threshold),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_of(input int i);
    int k;
    k = (i < 0) ? 0 : ((i > ROWS-1) ? ROWS-1 : i);
    return mem[k];
  endfunction

  // Reference: gray = (R+G+B)/3 in plain integers, white if strictly above thr.
  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] row, input int thr);
    logic [RW-1:0] res;
    int s;
    res = '0;
    for (int p = 0; p < COLS; p++) begin
      s = 0;
      for (int c = 0; c < 3; c++) s += int'(row[RW-1-24*p-8*c -: 8]);
      if (s / 3 > thr) res[RW-1-24*p -: 24] = 24'hFFFFFF;
    end
    return res;
  endfunction

  function automatic logic [RW-1:0] pix2(input int r0, g0, b0, r1, g1, b1);
    return {r0[7:0], g0[7:0], b0[7:0], r1[7:0], g1[7:0], b1[7:0]};
  endfunction

  task automatic run_frame(input int thr, input int rd_stall_row, input int wr_stall_row,
                           input int extra_start_cyc, input int abort_wr_addr, input int exp_cycles);
    int exp_rd, exp_wr, rd_hold, wr_hold, cyc;
    bit finished, aborted;
    exp_rd = 0; exp_wr = 0; finished = 0; aborted = 0;
    rd_hold = (rd_stall_row >= 0) ? 3 : 0;
    wr_hold = (wr_stall_row >= 0) ? 5 : 0;
    chk("idle_busy", busy, 0);
    start = 1'b1; threshold = thr[7:0];
    @(negedge CLK);
    start = 1'b0; threshold = 8'($urandom);
    cyc = 2;
    while (!finished && !aborted && cyc < 300) begin
      if (done) begin
        chk("done_cycle", cyc, exp_cycles);
        chk("done_reads", exp_rd, ROWS);
        chk("done_writes", exp_wr, ROWS);
        chk("done_busy", busy, 0);
        finished = 1;
      end else if (wr_en && exp_wr == abort_wr_addr) begin
        RST = 1'b0;
        #1;
        chk("rst_outputs", {busy, done, rd_req, rd_addr, wr_en, wr_addr}, 0);
        chk("rst_wr_data", wr_data, 0);
        @(negedge CLK);
        chk("rst_no_done", done, 0);
        RST = 1'b1;
        aborted = 1;
      end else begin
        chk("busy", busy, 1);
        if (rd_req) begin
          chk("rd_addr", rd_addr, exp_rd);
          rd_data = row_of(exp_rd);
          if (exp_rd == rd_stall_row && rd_hold > 0) begin
            rd_valid = 1'b0; rd_hold--;
          end else begin
            rd_valid = 1'b1; exp_rd++;
          end
        end else begin
          rd_valid = 1'($urandom_range(0, 1));
          rd_data  = RW'({$urandom, $urandom});
        end
        if (wr_en) begin
          chk("wr_addr", wr_addr, exp_wr);
          chk("wr_data", wr_data, model_row(row_of(exp_wr), thr));
          chk("win_top", dut.top_q, row_of(exp_wr - 1));
          chk("win_mid", dut.mid_q, row_of(exp_wr));
          chk("win_bot", dut.bot_q, row_of(exp_wr + 1));
          chk("wr_after_rd", exp_rd >= ((exp_wr + 2 < ROWS) ? exp_wr + 2 : ROWS), 1);
          if (exp_wr == wr_stall_row && wr_hold > 0) begin
            wr_ready = 1'b0; wr_hold--;
          end else begin
            wr_ready = 1'b1; exp_wr++;
          end
        end else begin
          wr_ready = 1'($urandom_range(0, 1));
        end
        if (cyc == extra_start_cyc) begin
          start = 1'b1; threshold = 8'd200;
        end else begin
          start = 1'b0;
        end
      end
      if (!finished && !aborted) begin
        @(negedge CLK);
        cyc++;
      end
    end
    chk("frame_ended", finished | aborted, 1);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
    end
  endtask

  initial begin
    int base;
    RST = 1'b0; start = 1'b0; threshold = '0; rd_valid = 1'b0; wr_ready = 1'b0; rd_data = '0;
    base = 2 * ROWS + 2;
    repeat (2) @(negedge CLK);
    chk("reset_outputs", {busy, done, rd_req, rd_addr, wr_en, wr_addr}, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_window", dut.mid_q, 0);
    RST = 1'b1;
    @(negedge CLK);

    // Basic frame: pixel0 gray 30 (black), pixel1 gray 43 (white).
    for (int i = 0; i < ROWS; i++) mem[i] = pix2(30, 30, 30, 50, 40, 40);
    run_frame(40, -1, -1, -1, -1, base);

    // Gray boundaries around thr=40 and a full-scale pixel.
    mem[0] = pix2(41, 41, 40, 41, 41, 41);
    mem[1] = pix2(255, 255, 255, 0, 0, 0);
    mem[2] = pix2(40, 41, 41, 42, 42, 42);
    mem[3] = pix2(41, 40, 41, 255, 255, 255);
    run_frame(40, -1, -1, -1, -1, base);

    // Tagged rows make window ordering visible.
    for (int i = 0; i < ROWS; i++) mem[i] = pix2(10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1));
    run_frame(25, -1, -1, -1, -1, base);

    // Back-pressure on both ports.
    for (int i = 0; i < ROWS; i++) mem[i] = RW'({$urandom, $urandom});
    run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, ROWS-1)),
              int'($urandom_range(0, ROWS-1)), -1, -1, base + 8);

    // Reset during the write of row 1, then a clean restart.
    run_frame(100, -1, -1, -1, 1, base);
    run_frame(100, -1, -1, -1, -1, base);

    // Start pulsed mid-frame with a different threshold must be ignored.
    for (int i = 0; i < ROWS; i++) mem[i] = pix2(30, 30, 30, 50, 40, 40);
    run_frame(40, -1, -1, 5, -1, base);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < ROWS; i++) mem[i] = RW'({$urandom, $urandom});
      run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, ROWS-1)),
                int'($urandom_range(0, ROWS-1)), -1, -1, base + 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
